step_motor_sequencer: RTL and testbench

Generates two-phase H-bridge drive signals (AX/AY/BX/BY plus coil enables AE/BE) for one bipolar stepper motor; one instance per motor feeds the `*_step_motor_0/1` nets that the pin matrix routes to the PIO26 headers. A host-side register block programs a step period, step count, direction and step mode, then pulses `start`. The block emits exactly the requested number of full or half steps at the programmed rate, tracks absolute position, and signals completion.

---
 rtl/step_motor_sequencer.sv | 151 +++++++++++++++
 tb/tb_step_motor_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/step_motor_sequencer.sv
// step_motor_sequencer: drives the H-bridge legs and enables of one bipolar
// stepper. A move emits a programmed number of full or half steps at a fixed
// cycle period, tracks absolute position and pulses done when it ends.
//
// state | meaning
// IDLE  | no move; coils follow hold_en, ph/position retained
// RUN   | move in progress; one step issued every eff_period cycles
module step_motor_sequencer #(
  parameter int PERIOD_W = 32,
  parameter int COUNT_W  = 16
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                start,
  input  logic                stop,
  input  logic                dir,
  input  logic                half_step,
  input  logic                hold_en,
  input  logic [PERIOD_W-1:0] period,
  input  logic [COUNT_W-1:0]  steps,
  output logic                AX,
  output logic                AY,
  output logic                BX,
  output logic                BY,
  output logic                AE,
  output logic                BE,
  output logic                busy,
  output logic                done,
  output logic [31:0]         position,
  output logic [COUNT_W-1:0]  remaining
);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [2:0]          ph_q, ph_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                dir_q, dir_d;
  logic                half_q, half_d;
  logic [COUNT_W-1:0]  remaining_q, remaining_d;
  logic [31:0]         position_q, position_d;
  logic                done_q, done_d;
  logic [5:0]          coil_q, coil_d;
  logic [PERIOD_W-1:0] eff_period;
  logic [2:0]          ph_inc;

  // Phase table packed as {AX, AY, BX, BY, AE, BE}; a leg pair of 00 leaves
  // that coil floating with its enable low.
  function automatic logic [5:0] coil_tbl(input logic [2:0] p);
    logic a_pos, a_neg, b_pos, b_neg;
    a_pos = (p == 3'd7) || (p == 3'd0) || (p == 3'd1);
    a_neg = (p == 3'd3) || (p == 3'd4) || (p == 3'd5);
    b_pos = (p == 3'd1) || (p == 3'd2) || (p == 3'd3);
    b_neg = (p == 3'd5) || (p == 3'd6) || (p == 3'd7);
    return {a_pos, a_neg, b_pos, b_neg, a_pos | a_neg, b_pos | b_neg};
  endfunction

  // Periods below 2 would step every cycle or never; clamp to 2.
  assign eff_period = (period < PERIOD_W'(2)) ? PERIOD_W'(2) : period;
  assign ph_inc     = half_q ? 3'd1 : 3'd2;

  // Next-state, step issue and coil output selection.
  always_comb begin
    state_d     = state_q;
    ph_d        = ph_q;
    cnt_d       = cnt_q;
    period_d    = period_q;
    dir_d       = dir_q;
    half_d      = half_q;
    remaining_d = remaining_q;
    position_d  = position_q;
    done_d      = 1'b0;
    coil_d      = 6'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          if (steps != '0) begin
            state_d     = S_RUN;
            cnt_d       = '0;
            remaining_d = steps;
            dir_d       = dir;
            half_d      = half_step;
            period_d    = eff_period;
            // Full-step moves only use the two-coil-on (odd) phases.
            ph_d        = half_step ? ph_q : (ph_q | 3'd1);
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (cnt_q == period_q - PERIOD_W'(1)) begin
          cnt_d       = '0;
          ph_d        = dir_q ? (ph_q + ph_inc) : (ph_q - ph_inc);
          position_d  = dir_q ? (position_q + 32'd1) : (position_q - 32'd1);
          remaining_d = remaining_q - COUNT_W'(1);
          if (remaining_q == COUNT_W'(1)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + PERIOD_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_RUN || hold_en) begin
      coil_d = coil_tbl(ph_d);
    end
  end

  // State and datapath registers; reset de-energizes the bridge immediately.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      ph_q        <= 3'd0;
      cnt_q       <= '0;
      period_q    <= PERIOD_W'(2);
      dir_q       <= 1'b0;
      half_q      <= 1'b0;
      remaining_q <= '0;
      position_q  <= 32'd0;
      done_q      <= 1'b0;
      coil_q      <= 6'b0;
    end else begin
      state_q     <= state_d;
      ph_q        <= ph_d;
      cnt_q       <= cnt_d;
      period_q    <= period_d;
      dir_q       <= dir_d;
      half_q      <= half_d;
      remaining_q <= remaining_d;
      position_q  <= position_d;
      done_q      <= done_d;
      coil_q      <= coil_d;
    end
  end

  assign {AX, AY, BX, BY, AE, BE} = coil_q;
  assign busy      = (state_q == S_RUN);
  assign done      = done_q;
  assign position  = position_q;
  assign remaining = remaining_q;

endmodule

// File: tb/tb_step_motor_sequencer.sv
// Bench for step_motor_sequencer. Stimulus pushes every expected change of the
// observable outputs (cycle index + snapshot) into a queue; the monitor pops
// one entry whenever the sampled outputs differ from the previous sample.
module tb_step_motor_sequencer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        dir = 1'b0;
  logic        half_step = 1'b0;
  logic        hold_en = 1'b0;
  logic [31:0] period = 32'd0;
  logic [15:0] steps = 16'd0;
  logic        AX, AY, BX, BY, AE, BE;
  logic        busy, done;
  logic [31:0] position;
  logic [15:0] remaining;

  typedef struct {
    int          cyc;
    logic [55:0] snap;
  } exp_t;

  exp_t        exp_q[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  bit          mon_en = 1'b0;
  logic [55:0] prev_snap;

  step_motor_sequencer #(.PERIOD_W(32), .COUNT_W(16)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .stop(stop),
    .dir(dir), .half_step(half_step), .hold_en(hold_en),
    .period(period), .steps(steps),
    .AX(AX), .AY(AY), .BX(BX), .BY(BY), .AE(AE), .BE(BE),
    .busy(busy), .done(done), .position(position), .remaining(remaining)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  function automatic logic [55:0] cur_snap();
    return {AX, AY, BX, BY, AE, BE, busy, done, position, remaining};
  endfunction

  // coil = {AX,AY,BX,BY,AE,BE}
  task automatic expect_at(input int c, input logic [5:0] coil, input bit b,
                           input bit d, input int pos, input int rem);
    exp_t e;
    e.cyc  = c;
    e.snap = {coil, b, d, 32'(pos), 16'(rem)};
    exp_q.push_back(e);
  endtask

  // Monitor: every change of outputs consumes one expected entry.
  always @(negedge clock) begin
    logic [55:0] s;
    exp_t e;
    s = cur_snap();
    if (mon_en && s !== prev_snap) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_change cyc=%0d got=%h want=<no change>", cyc, s);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.snap !== s)
          $display("FAIL event cyc got=%0d want=%0d snap got=%h want=%h",
                   cyc, e.cyc, s, e.snap);
        else
          n_pass++;
      end
    end
    prev_snap = s;
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clock);
  endtask

  // Called just after a negedge; start is sampled on the following posedge.
  task automatic go(input bit hs, input bit dr, input logic [31:0] per,
                    input logic [15:0] st);
    start = 1'b1; half_step = hs; dir = dr; period = per; steps = st;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic check_zero(input string name);
    n_checks++;
    if (cur_snap() !== 56'd0)
      $display("FAIL %s got=%h want=%h", name, cur_snap(), 56'd0);
    else
      n_pass++;
  endtask

  initial begin
    int t0;
    repeat (3) @(negedge clock);
    check_zero("reset_state");
    reset_n = 1'b1;
    @(negedge clock);
    check_zero("idle_after_reset");
    mon_en = 1'b1;

    // Full-step forward, ph 0 forced to 1
    t0 = cyc + 1;
    hold_en = 1'b1;
    expect_at(t0,      6'b101011, 1, 0, 0, 4);
    expect_at(t0 + 4,  6'b011011, 1, 0, 1, 3);
    expect_at(t0 + 8,  6'b010111, 1, 0, 2, 2);
    expect_at(t0 + 12, 6'b100111, 1, 0, 3, 1);
    expect_at(t0 + 16, 6'b101011, 0, 1, 4, 0);
    expect_at(t0 + 17, 6'b101011, 0, 0, 4, 0);
    go(1'b0, 1'b1, 32'd4, 16'd4);
    wait_cyc(t0 + 17);

    // Half-step reverse with 0 -> 7 phase wrap
    t0 = cyc + 1;
    expect_at(t0,     6'b101011, 1, 0, 4, 3);
    expect_at(t0 + 2, 6'b100010, 1, 0, 3, 2);
    expect_at(t0 + 4, 6'b100111, 1, 0, 2, 1);
    expect_at(t0 + 6, 6'b000101, 0, 1, 1, 0);
    expect_at(t0 + 7, 6'b000101, 0, 0, 1, 0);
    go(1'b1, 1'b0, 32'd2, 16'd3);
    wait_cyc(t0 + 7);

    // Period 0 clamps to 2; position crosses zero into negative
    t0 = cyc + 1;
    expect_at(t0,     6'b100111, 1, 0, 1, 2);
    expect_at(t0 + 2, 6'b010111, 1, 0, 0, 1);
    expect_at(t0 + 4, 6'b011011, 0, 1, -1, 0);
    expect_at(t0 + 5, 6'b011011, 0, 0, -1, 0);
    go(1'b0, 1'b0, 32'd0, 16'd2);
    wait_cyc(t0 + 5);

    // Zero-step start: done only, busy stays low
    t0 = cyc + 1;
    expect_at(t0,     6'b011011, 0, 1, -1, 0);
    expect_at(t0 + 1, 6'b011011, 0, 0, -1, 0);
    go(1'b0, 1'b1, 32'd3, 16'd0);
    wait_cyc(t0 + 2);

    // Abort after two steps; a start during RUN is ignored
    t0 = cyc + 1;
    expect_at(t0,      6'b011011, 1, 0, -1, 100);
    expect_at(t0 + 10, 6'b010010, 1, 0, 0, 99);
    expect_at(t0 + 20, 6'b010111, 1, 0, 1, 98);
    expect_at(t0 + 25, 6'b010111, 0, 1, 1, 98);
    expect_at(t0 + 26, 6'b010111, 0, 0, 1, 98);
    expect_at(t0 + 28, 6'b000000, 0, 0, 1, 98);
    go(1'b1, 1'b1, 32'd10, 16'd100);
    wait_cyc(t0 + 5);
    go(1'b0, 1'b0, 32'd2, 16'd7);
    wait_cyc(t0 + 24);
    stop = 1'b1;
    @(negedge clock);
    stop = 1'b0;
    wait_cyc(t0 + 27);
    hold_en = 1'b0;
    wait_cyc(t0 + 29);

    // start together with stop in IDLE: ignored
    start = 1'b1; stop = 1'b1; steps = 16'd5; period = 32'd2;
    @(negedge clock);
    start = 1'b0; stop = 1'b0;
    repeat (4) @(negedge clock);

    // Asynchronous reset in the middle of a move
    t0 = cyc + 1;
    hold_en = 1'b1;
    expect_at(t0,     6'b010111, 1, 0, 1, 10);
    expect_at(t0 + 3, 6'b100111, 1, 0, 2, 9);
    expect_at(t0 + 5, 6'b000000, 0, 0, 0, 0);
    expect_at(t0 + 7, 6'b100010, 0, 0, 0, 0);
    go(1'b0, 1'b1, 32'd3, 16'd10);
    wait_cyc(t0 + 4);
    #2 reset_n = 1'b0;
    #1 check_zero("async_reset");
    wait_cyc(t0 + 6);
    reset_n = 1'b1;
    repeat (6) @(negedge clock);

    n_checks++;
    if (exp_q.size() != 0)
      $display("FAIL pending_events got=%0d want=0", exp_q.size());
    else
      n_pass++;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog got=timeout want=finish");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog");
  end

endmodule
